// File: rtl/axi_burst_master_if.sv
// AXI4 master-side channel bundle (AW/W/B/AR/R) used by axi_burst_master.
// The master modport is the bridge's view; the slave modport is the interconnect's view.
interface axi_burst_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awlock;
    logic [3:0]            awqos;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arlock;
    logic [3:0]            arqos;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awqos,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arqos,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awqos,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arqos,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Host-to-AXI4 bridge issuing INCR bursts of 1..MAX_BEATS beats, including narrow beats.
// Write and read beats stream over valid/ready host ports; status is decoded from the state.
module axi_burst_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_rw,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [2:0]           i_size,
    input  logic [7:0]           i_len,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic                 i_wvalid,
    output logic                 o_wready,
    output logic [DATA_W-1:0]    o_rdata,
    output logic                 o_rvalid,
    output logic                 o_rlast,
    output logic                 o_wait,
    input  logic                 i_clear,
    output logic                 o_done,
    output logic                 o_error,
    output logic                 o_invalid,
    axi_burst_master_if.master   m_axi
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);

    typedef enum logic [3:0] {
        IDLE, DONE, ERROR, INVALID, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LSB-1:0]    lane_q;
    logic [2:0]        size_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic              awvalid_q;
    logic              arvalid_q;
    logic [1:0]        resp_q;

    logic              idleClass;
    logic              reqValid;
    logic              reqBad;
    logic [7:0]        reqBytes;
    logic [8:0]        beatsReq;
    logic [16:0]       pageEnd;
    logic [7:0]        sizeBytes;
    logic              lastBeat;
    logic              wHs;
    logic              rBeat;
    logic              rDone;
    logic [1:0]        rWorst;
    logic [1:0]        finResp;
    logic              finish;
    logic              finErr;
    state_e            finState;

    // Request screening: misaligned, wider than the bus, too long, or crossing a 4 KB page.
    always_comb begin
        idleClass = state_q inside {IDLE, DONE, ERROR, INVALID};
        reqValid  = idleClass && (i_rw == 2'b01 || i_rw == 2'b10);
        reqBytes  = 8'd1 << i_size;
        beatsReq  = {1'b0, i_len} + 9'd1;
        pageEnd   = {5'd0, i_addr[11:0]} + ({8'd0, beatsReq} << i_size);
        reqBad    = ((i_addr[7:0] & (reqBytes - 8'd1)) != 8'd0)
                 || (i_size > 3'(LSB))
                 || ({23'd0, beatsReq} > 32'(MAX_BEATS))
                 || (pageEnd > 17'd4096);
    end

    // Completion is shared by W_RESP and R_DATA; read responses keep the worst code seen.
    always_comb begin
        sizeBytes = 8'd1 << size_q;
        lastBeat  = cnt_q == len_q;
        wHs       = (state_q == W_DATA) && i_wvalid && m_axi.wready;
        rBeat     = (state_q == R_DATA) && m_axi.rvalid;
        rDone     = rBeat && (m_axi.rlast || lastBeat);
        rWorst    = (m_axi.rresp > resp_q) ? m_axi.rresp : resp_q;
        finResp   = (state_q == W_RESP) ? m_axi.bresp : rWorst;
        finish    = ((state_q == W_RESP) && m_axi.bvalid) || rDone;
        finErr    = (finResp != 2'b00) || (rDone && (m_axi.rlast != lastBeat));
        if (i_clear)                 finState = IDLE;
        else if (finResp == 2'b11)   finState = INVALID;
        else if (finErr)             finState = ERROR;
        else                         finState = DONE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            resp_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR, INVALID: begin
                    if (reqValid) begin
                        addr_q <= i_addr;
                        lane_q <= i_addr[LSB-1:0];
                        size_q <= i_size;
                        len_q  <= i_len;
                        cnt_q  <= '0;
                        resp_q <= '0;
                        if (reqBad) begin
                            state_q <= INVALID;
                        end else if (i_rw == 2'b01) begin
                            state_q   <= W_ADDR;
                            awvalid_q <= 1'b1;
                        end else begin
                            state_q   <= R_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end else if (i_clear) begin
                        state_q <= IDLE;
                    end
                end
                W_ADDR: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wHs) begin
                        if (lastBeat) begin
                            state_q <= W_RESP;
                        end else begin
                            cnt_q  <= cnt_q + 8'd1;
                            lane_q <= lane_q + sizeBytes[LSB-1:0];
                        end
                    end
                end
                W_RESP: begin
                    if (finish) state_q <= finState;
                end
                R_ADDR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rBeat) begin
                        resp_q <= rWorst;
                        cnt_q  <= cnt_q + 8'd1;
                        lane_q <= lane_q + sizeBytes[LSB-1:0];
                        if (rDone) state_q <= finState;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_done    = finish || (state_q inside {DONE, ERROR, INVALID});
    assign o_error   = (finish && finErr) || (state_q inside {ERROR, INVALID});
    assign o_invalid = (finish && finResp == 2'b11) || (state_q == INVALID);
    assign o_wait    = !idleClass && !finish;

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = size_q;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awcache = 4'b0011;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awqos   = 4'b0000;

    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = size_q;
    assign m_axi.arburst = 2'b01;
    assign m_axi.arcache = 4'b0011;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arqos   = 4'b0000;

    // Host data is LSB-justified; the beat's byte lane places it on the bus and back.
    assign m_axi.wvalid = (state_q == W_DATA) && i_wvalid;
    assign o_wready     = (state_q == W_DATA) && m_axi.wready;
    assign m_axi.wdata  = (state_q == W_DATA) ? (i_wdata << {lane_q, 3'b000}) : '0;
    assign m_axi.wstrb  = (state_q == W_DATA) ? (~({STRB_W{1'b1}} << sizeBytes) << lane_q) : '0;
    assign m_axi.wlast  = (state_q == W_DATA) && lastBeat;
    assign m_axi.bready = (state_q == W_RESP);

    assign m_axi.rready = (state_q == R_DATA);
    assign o_rvalid     = rBeat;
    assign o_rlast      = rDone;
    assign o_rdata      = rBeat ? ((m_axi.rdata >> {lane_q, 3'b000})
                                   & ~({DATA_W{1'b1}} << {sizeBytes, 3'b000})) : '0;
endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: directed vector table, hand-written corner
// sequences and randomized bursts, all checked against a byte-lane reference model.
module tb_axi_burst_master;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MAX_BEATS = 16;
    localparam int STRB_W    = DATA_W / 8;

    typedef struct {
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [1:0]  resp;
        bit          expBad;
        bit          expErr;
        bit          expInv;
    } vec_t;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [1:0]        i_rw = '0;
    logic [31:0]       i_addr = '0;
    logic [2:0]        i_size = '0;
    logic [7:0]        i_len = '0;
    logic [63:0]       i_wdata = '0;
    logic              i_wvalid = 1'b0;
    logic              i_clear = 1'b0;
    logic              o_wready;
    logic [63:0]       o_rdata;
    logic              o_rvalid;
    logic              o_rlast;
    logic              o_wait;
    logic              o_done;
    logic              o_error;
    logic              o_invalid;

    int nVec = 0;
    int nMis = 0;
    int txnId = 0;

    logic [63:0] wBeatData [256];
    logic [63:0] rBeatData [256];
    logic [1:0]  rBeatResp [256];

    always #5 i_clk = ~i_clk;

    axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axi_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rw      (i_rw),
        .i_addr    (i_addr),
        .i_size    (i_size),
        .i_len     (i_len),
        .i_wdata   (i_wdata),
        .i_wvalid  (i_wvalid),
        .o_wready  (o_wready),
        .o_rdata   (o_rdata),
        .o_rvalid  (o_rvalid),
        .o_rlast   (o_rlast),
        .o_wait    (o_wait),
        .i_clear   (i_clear),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_invalid (o_invalid),
        .m_axi     (axi)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", name, txnId, act, exp);
        end
    endtask

    // Reference model: byte-lane arithmetic straight from the burst rules.
    function automatic bit reqIsBad(logic [31:0] addr, logic [2:0] size, logic [7:0] len);
        int n     = 1 << size;
        int beats = int'(len) + 1;
        int off   = int'(addr[11:0]);
        return (int'(addr % 32'(n)) != 0) || (n > STRB_W) || (beats > MAX_BEATS) || (off + beats * n > 4096);
    endfunction

    function automatic int laneOf(logic [31:0] addr, logic [2:0] size, int k);
        int n = 1 << size;
        return int'((addr + 32'(k * n)) % 32'(STRB_W));
    endfunction

    function automatic logic [63:0] hostMask(logic [63:0] d, logic [2:0] size);
        logic [63:0] r = '0;
        for (int j = 0; j < (1 << size); j++) r[8*j +: 8] = d[8*j +: 8];
        return r;
    endfunction

    function automatic logic [7:0] expStrb(logic [31:0] addr, logic [2:0] size, int k);
        logic [7:0] s = '0;
        int lane = laneOf(addr, size, k);
        for (int j = 0; j < (1 << size); j++) s[lane + j] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] expWdata(logic [31:0] addr, logic [2:0] size, int k, logic [63:0] d);
        logic [63:0] r = '0;
        int lane = laneOf(addr, size, k);
        for (int j = 0; j < (1 << size); j++) r[8*(lane + j) +: 8] = d[8*j +: 8];
        return r;
    endfunction

    function automatic logic [63:0] expRdata(logic [31:0] addr, logic [2:0] size, int k, logic [63:0] d);
        logic [63:0] r = '0;
        int lane = laneOf(addr, size, k);
        for (int j = 0; j < (1 << size); j++) r[8*j +: 8] = d[8*(lane + j) +: 8];
        return r;
    endfunction

    // One complete host request with a cooperative (randomly stalling) slave.
    task automatic applyStimulus(input logic [1:0] rw, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [7:0] len, input logic [1:0] bresp, input int lastAt,
                                 input bit expBad, input bit expErr, input bit expInv, input bit doClear);
        int  k;
        int  guard;
        int  comp;
        bit  wv;
        bit  wr;
        bit  rv;
        txnId++;
        @(negedge i_clk);
        i_rw = rw; i_addr = addr; i_size = size; i_len = len;
        @(negedge i_clk);
        i_rw = 2'b00;
        #1;
        if (expBad) begin
            checkOutput("invalid_status", {o_done, o_error, o_invalid, o_wait}, 4'b1110);
            checkOutput("invalid_no_addr", {axi.awvalid, axi.arvalid}, 2'b00);
        end else begin
            checkOutput("start_wait", {o_wait, o_done}, 2'b10);
            if (rw == 2'b01) begin
                checkOutput("aw_valid", {axi.awvalid, axi.arvalid}, 2'b10);
                checkOutput("aw_fields", {axi.awaddr, axi.awlen, axi.awsize}, {addr, len, size});
                checkOutput("aw_const", {axi.awburst, axi.awcache, axi.awprot, axi.awlock, axi.awqos},
                            {2'b01, 4'b0011, 3'b000, 1'b0, 4'b0000});
            end else begin
                checkOutput("ar_valid", {axi.awvalid, axi.arvalid}, 2'b01);
                checkOutput("ar_fields", {axi.araddr, axi.arlen, axi.arsize}, {addr, len, size});
                checkOutput("ar_const", {axi.arburst, axi.arcache, axi.arprot, axi.arlock, axi.arqos},
                            {2'b01, 4'b0011, 3'b000, 1'b0, 4'b0000});
            end
            repeat ($urandom_range(0, 2)) begin
                @(negedge i_clk); #1;
                checkOutput("addr_hold", {axi.awvalid, axi.arvalid}, (rw == 2'b01) ? 2'b10 : 2'b01);
            end
            if (rw == 2'b01) axi.awready = 1'b1; else axi.arready = 1'b1;
            @(negedge i_clk);
            axi.awready = 1'b0; axi.arready = 1'b0;
            #1;
            checkOutput("addr_drop", {axi.awvalid, axi.arvalid}, 2'b00);
            k = 0; guard = 0;
            if (rw == 2'b01) begin
                while (k <= int'(len) && guard < 1000) begin
                    wv = ($urandom_range(0, 3) != 0);
                    wr = ($urandom_range(0, 3) != 0);
                    i_wvalid = wv; axi.wready = wr; i_wdata = hostMask(wBeatData[k], size);
                    #1;
                    checkOutput("w_pass", {axi.wvalid, o_wready, o_wait}, {wv, wr, 1'b1});
                    if (wv) begin
                        checkOutput("w_strb", axi.wstrb, expStrb(addr, size, k));
                        checkOutput("w_data", axi.wdata, expWdata(addr, size, k, i_wdata));
                        checkOutput("w_last", axi.wlast, k == int'(len));
                    end
                    if (wv && wr) k++;
                    @(negedge i_clk);
                    guard++;
                end
                if (guard >= 1000) checkOutput("w_timeout", 1'b0, 1'b1);
                i_wvalid = 1'b0; axi.wready = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    #1;
                    checkOutput("b_wait", {axi.bready, o_done, o_wait}, 3'b101);
                    @(negedge i_clk);
                end
                axi.bvalid = 1'b1; axi.bresp = bresp;
                #1;
                checkOutput("b_done", {axi.bready, o_done, o_error, o_invalid, o_wait}, {1'b1, 1'b1, expErr, expInv, 1'b0});
                @(negedge i_clk);
                axi.bvalid = 1'b0; axi.bresp = 2'b00;
            end else begin
                comp = (lastAt < int'(len)) ? lastAt : int'(len);
                while (k <= comp && guard < 1000) begin
                    rv = ($urandom_range(0, 3) != 0);
                    axi.rvalid = rv; axi.rdata = rBeatData[k]; axi.rresp = rBeatResp[k];
                    axi.rlast = (k == lastAt);
                    #1;
                    checkOutput("r_pass", {axi.rready, o_rvalid}, {1'b1, rv});
                    if (rv) begin
                        checkOutput("r_data", o_rdata, expRdata(addr, size, k, rBeatData[k]));
                        checkOutput("r_last", {o_rlast, o_done}, {k == comp, k == comp});
                        if (k == comp)
                            checkOutput("r_status", {o_error, o_invalid, o_wait}, {expErr, expInv, 1'b0});
                        k++;
                    end else begin
                        checkOutput("r_idle", {o_done, o_wait}, 2'b01);
                    end
                    @(negedge i_clk);
                    guard++;
                end
                if (guard >= 1000) checkOutput("r_timeout", 1'b0, 1'b1);
                axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
            end
            #1;
            checkOutput("final_status", {o_done, o_error, o_invalid, o_wait}, {1'b1, expErr, expInv, 1'b0});
        end
        if (doClear) begin
            i_clear = 1'b1;
            @(negedge i_clk);
            i_clear = 1'b0;
            #1;
            checkOutput("cleared", {o_done, o_error, o_invalid, o_wait}, 4'b0000);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[11];
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [1:0]  bresp;
        int          lastAt;
        int          comp;
        logic [1:0]  worst;
        bit          bad;
        bit          err;
        bit          inv;

        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;

        vecs[0]  = '{2'b01, 32'h0000_1000, 3'd3, 8'd3,  2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 32'h0000_2002, 3'd1, 8'd3,  2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b01, 32'h0000_0007, 3'd0, 8'd1,  2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 32'h0000_0FF8, 3'd3, 8'd1,  2'b00, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{2'b10, 32'h0000_0002, 3'd2, 8'd0,  2'b00, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{2'b01, 32'h0000_0000, 3'd0, 8'd16, 2'b00, 1'b1, 1'b1, 1'b1};
        vecs[6]  = '{2'b10, 32'h0000_0000, 3'd4, 8'd0,  2'b00, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{2'b01, 32'h0000_0040, 3'd2, 8'd3,  2'b10, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{2'b01, 32'h0000_0080, 3'd3, 8'd0,  2'b11, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{2'b10, 32'h0000_0FF0, 3'd3, 8'd1,  2'b00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2'b10, 32'h0000_0300, 3'd3, 8'd15, 2'b01, 1'b0, 1'b1, 1'b0};

        #1;
        checkOutput("reset_status", {o_done, o_error, o_invalid, o_wait, o_rvalid, o_rlast, o_wready}, 7'd0);
        checkOutput("reset_bus", {axi.awvalid, axi.arvalid, axi.wvalid, axi.bready, axi.rready, axi.awaddr}, '0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int v = 0; v < 11; v++) begin
            for (int b = 0; b < 256; b++) begin
                wBeatData[b] = {$urandom, $urandom};
                rBeatData[b] = 64'h8877_6655_4433_2211;
                rBeatResp[b] = vecs[v].resp;
            end
            applyStimulus(vecs[v].rw, vecs[v].addr, vecs[v].size, vecs[v].len, vecs[v].resp, int'(vecs[v].len),
                          vecs[v].expBad, vecs[v].expErr, vecs[v].expInv, 1'b1);
        end

        // Read with a SLVERR in the middle beat, then one whose rlast arrives a beat early.
        rBeatResp[0] = 2'b00; rBeatResp[1] = 2'b10; rBeatResp[2] = 2'b00;
        applyStimulus(2'b10, 32'h0000_3000, 3'd3, 8'd2, 2'b00, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        rBeatResp[1] = 2'b00;
        applyStimulus(2'b10, 32'h0000_3100, 3'd3, 8'd2, 2'b00, 1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reserved opcode behaves as idle.
        txnId++;
        @(negedge i_clk);
        i_rw = 2'b11; i_addr = 32'h0000_4000; i_size = 3'd3; i_len = 8'd0;
        @(negedge i_clk);
        i_rw = 2'b00;
        #1;
        checkOutput("rw11_idle", {axi.awvalid, axi.arvalid, o_wait, o_done}, 4'b0000);

        // Asynchronous reset while the second of four write beats is on the bus.
        txnId++;
        @(negedge i_clk);
        i_rw = 2'b01; i_addr = 32'h0000_1000; i_size = 3'd3; i_len = 8'd3;
        @(negedge i_clk);
        i_rw = 2'b00; axi.awready = 1'b1;
        @(negedge i_clk);
        axi.awready = 1'b0; i_wvalid = 1'b1; axi.wready = 1'b1; i_wdata = 64'h1111;
        @(negedge i_clk);
        i_wdata = 64'h2222;
        #1;
        checkOutput("rst_pre", {axi.wvalid, axi.wdata, o_wait}, {1'b1, 64'h2222, 1'b1});
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("rst_async", {axi.wvalid, axi.awvalid, axi.wstrb, o_wait, o_done}, '0);
        @(negedge i_clk);
        i_rst_n = 1'b1; i_wvalid = 1'b0; axi.wready = 1'b0;
        #1;
        checkOutput("rst_idle", {axi.awvalid, axi.arvalid, o_wait, o_done, o_error}, '0);

        for (int t = 0; t < 40; t++) begin
            rw   = 2'($urandom_range(1, 2));
            size = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 7));
            addr = (32'($urandom_range(0, 7)) << 12) | 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) == 0) addr[11:0] = 12'(4096 - 8 * $urandom_range(1, 8));
            if ($urandom_range(0, 9) != 0 && size <= 3'd3) addr = addr & ~((32'd1 << size) - 32'd1);
            bresp  = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            lastAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len) + 1)) : int'(len);
            for (int b = 0; b < 256; b++) begin
                wBeatData[b] = {$urandom, $urandom};
                rBeatData[b] = {$urandom, $urandom};
                rBeatResp[b] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            end
            bad = reqIsBad(addr, size, len);
            if (rw == 2'b01) begin
                err = (bresp != 2'b00);
                inv = (bresp == 2'b11);
            end else begin
                comp  = (lastAt < int'(len)) ? lastAt : int'(len);
                worst = 2'b00;
                for (int b = 0; b <= comp; b++) if (rBeatResp[b] > worst) worst = rBeatResp[b];
                err = (worst != 2'b00) || (lastAt != int'(len));
                inv = (worst == 2'b11);
            end
            if (bad) begin err = 1'b1; inv = 1'b1; end
            applyStimulus(rw, addr, size, len, bresp, lastAt, bad, err, inv, $urandom_range(0, 1) == 1);
        end

        repeat (2) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
